// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter between NUM_PORTS L1 line ports and one L2 line port.
// The winning request is latched and held downstream until L2 answers.
module mem_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             read_i,
    input  logic [NUM_PORTS-1:0]             write_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  wdata_i,
    output logic [NUM_PORTS-1:0]             resp_o,
    output logic [LINE_WIDTH-1:0]            rdata_o,
    output logic                             l2_read_o,
    output logic                             l2_write_o,
    output logic [ADDR_WIDTH-1:0]            l2_addr_o,
    output logic [LINE_WIDTH-1:0]            l2_wdata_o,
    input  logic                             l2_resp_i,
    input  logic [LINE_WIDTH-1:0]            l2_rdata_i,
    output logic                             busy_o,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_o
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [IDX_W-1:0]       ptr_r;
    logic [IDX_W-1:0]       grant_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [LINE_WIDTH-1:0]  wdata_r;
    logic                   l2_read_r;
    logic                   l2_write_r;
    logic                   busy_r;

    logic [NUM_PORTS-1:0]   req_s;
    logic                   win_found_s;
    logic [IDX_W-1:0]       win_idx_s;
    int                     cand_s;
    logic                   sel_write_s;
    logic [ADDR_WIDTH-1:0]  sel_addr_s;
    logic [LINE_WIDTH-1:0]  sel_wdata_s;
    logic [IDX_W-1:0]       next_ptr_s;
    logic [NUM_PORTS-1:0]   resp_s;

    assign req_s = read_i | write_i;

    // First requester at or after the priority pointer, wrapping at NUM_PORTS-1
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_s = int'(ptr_r) + i;
            if (cand_s >= NUM_PORTS) begin
                cand_s = cand_s - NUM_PORTS;
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && req_s[cand_s[IDX_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Select the winner's op, address and line; write has precedence over read
    always_comb begin
        sel_write_s = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (IDX_W'(i) == win_idx_s) begin
                sel_write_s = write_i[i];
                sel_addr_s  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata_s = wdata_i[i*LINE_WIDTH +: LINE_WIDTH];
            end else begin
                sel_write_s = sel_write_s;
            end
        end
    end

    // Pointer advance past the current grant
    always_comb begin
        if (grant_r == IDX_W'(NUM_PORTS - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_r + IDX_W'(1);
        end
    end

    // Completion pulse only while a transaction is in flight
    always_comb begin
        resp_s = '0;
        if (state_r == ST_BUSY && l2_resp_i) begin
            resp_s[grant_r] = 1'b1;
        end else begin
            resp_s = '0;
        end
    end

    // Arbitration FSM with latched request and registered strobes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            grant_r    <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            l2_read_r  <= 1'b0;
            l2_write_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        grant_r    <= win_idx_s;
                        addr_r     <= sel_addr_s;
                        wdata_r    <= sel_wdata_s;
                        l2_read_r  <= ~sel_write_s;
                        l2_write_r <= sel_write_s;
                        busy_r     <= 1'b1;
                        state_r    <= ST_BUSY;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (l2_resp_i) begin
                        ptr_r      <= next_ptr_s;
                        l2_read_r  <= 1'b0;
                        l2_write_r <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= ST_RELEASE;
                    end else begin
                        state_r    <= ST_BUSY;
                    end
                end
                ST_RELEASE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    l2_read_r  <= 1'b0;
                    l2_write_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_o     = resp_s;
    assign rdata_o    = l2_rdata_i;
    assign l2_read_o  = l2_read_r;
    assign l2_write_o = l2_write_r;
    assign l2_addr_o  = addr_r;
    assign l2_wdata_o = wdata_r;
    assign busy_o     = busy_r;
    assign grant_o    = grant_r;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr (3 ports): directed scenarios plus random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter_rr;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int LW = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NP-1:0]     read_i;
    logic [NP-1:0]     write_i;
    logic [NP*AW-1:0]  addr_i;
    logic [NP*LW-1:0]  wdata_i;
    logic [NP-1:0]     resp_o;
    logic [LW-1:0]     rdata_o;
    logic              l2_read_o;
    logic              l2_write_o;
    logic [AW-1:0]     l2_addr_o;
    logic [LW-1:0]     l2_wdata_o;
    logic              l2_resp_i;
    logic [LW-1:0]     l2_rdata_i;
    logic              busy_o;
    logic [1:0]        grant_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 = waiting, 1 = in flight, 2 = release cycle
    int             m_phase;
    int             m_ptr;
    int             m_grant;
    bit             m_write;
    logic [AW-1:0]  m_addr;
    logic [LW-1:0]  m_wdata;

    mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .read_i     (read_i),
        .write_i    (write_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .resp_o     (resp_o),
        .rdata_o    (rdata_o),
        .l2_read_o  (l2_read_o),
        .l2_write_o (l2_write_o),
        .l2_addr_o  (l2_addr_o),
        .l2_wdata_o (l2_wdata_o),
        .l2_resp_i  (l2_resp_i),
        .l2_rdata_i (l2_rdata_i),
        .busy_o     (busy_o),
        .grant_o    (grant_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [NP-1:0] exp_resp;
        bit            in_flight;
        in_flight = (m_phase == 1);
        exp_resp  = '0;
        if (in_flight && l2_resp_i) exp_resp[m_grant] = 1'b1;
        check_eq("busy",     64'(busy_o),     64'(in_flight));
        check_eq("grant",    64'(grant_o),    64'(m_grant));
        check_eq("resp",     64'(resp_o),     64'(exp_resp));
        check_eq("l2_read",  64'(l2_read_o),  64'(in_flight && !m_write));
        check_eq("l2_write", 64'(l2_write_o), 64'(in_flight && m_write));
        check_eq("rdata",    64'(rdata_o),    64'(l2_rdata_i));
        if (in_flight) check_eq("l2_addr", 64'(l2_addr_o), 64'(m_addr));
        if (in_flight && m_write) check_eq("l2_wdata", 64'(l2_wdata_o), 64'(m_wdata));
    endtask

    task automatic model_update();
        if (!reset_n) begin
            m_phase = 0;
            m_ptr   = 0;
            m_grant = 0;
        end else if (m_phase == 0) begin
            for (int i = 0; i < NP; i++) begin
                int k;
                k = (m_ptr + i) % NP;
                if (m_phase == 0 && (read_i[k] || write_i[k])) begin
                    m_phase = 1;
                    m_grant = k;
                    m_write = write_i[k];
                    m_addr  = addr_i[k*AW +: AW];
                    m_wdata = wdata_i[k*LW +: LW];
                end
            end
        end else if (m_phase == 1) begin
            if (l2_resp_i) begin
                m_ptr   = (m_grant + 1) % NP;
                m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    // One clock: check outputs, clock edge, advance model, return at negedge
    task automatic step();
        #1;
        compare_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_port(input int k, input logic [AW-1:0] a, input logic [LW-1:0] d);
        addr_i[k*AW +: AW]  = a;
        wdata_i[k*LW +: LW] = d;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    int order [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        reset_n    = 1'b0;
        read_i     = '0;
        write_i    = '0;
        addr_i     = '0;
        wdata_i    = '0;
        l2_resp_i  = 1'b0;
        l2_rdata_i = '0;
        m_phase = 0; m_ptr = 0; m_grant = 0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
        @(posedge clk);
        model_update();
        @(negedge clk);
        do_reset();
        #1;
        check_eq("rst_busy",  64'(busy_o),    64'd0);
        check_eq("rst_grant", 64'(grant_o),   64'd0);
        check_eq("rst_read",  64'(l2_read_o), 64'd0);

        // Single read from port 1
        read_i = 3'b010;
        set_port(1, 32'h0000_1000, 64'd0);
        step();
        read_i = 3'b000;
        #1;
        check_eq("sr_strobe", 64'(l2_read_o), 64'd1);
        check_eq("sr_addr",   64'(l2_addr_o), 64'h1000);
        for (int i = 0; i < 4; i++) step();
        l2_resp_i  = 1'b1;
        l2_rdata_i = {8{8'hA5}};
        #1;
        check_eq("sr_resp",  64'(resp_o),  64'h2);
        check_eq("sr_rdata", 64'(rdata_o), {8{8'hA5}});
        step();
        l2_resp_i = 1'b0;
        read_i    = 3'b010;
        #1;
        check_eq("sr_rel_resp", 64'(resp_o),    64'd0);
        check_eq("sr_rel_read", 64'(l2_read_o), 64'd0);
        step();
        read_i = 3'b000;
        step();

        // Fairness: all ports requesting, answer on the second busy cycle
        do_reset();
        read_i = 3'b111;
        for (int t = 0; t < 6; t++) begin
            set_port(0, 32'h100 + 32'(t), 64'd0);
            set_port(1, 32'h200 + 32'(t), 64'd0);
            set_port(2, 32'h300 + 32'(t), 64'd0);
            step();
            step();
            l2_resp_i = 1'b1;
            #1;
            check_eq("fair_grant", 64'(grant_o), 64'(order[t]));
            check_eq("fair_resp",  64'(resp_o),  64'(3'b001 << order[t]));
            step();
            l2_resp_i = 1'b0;
            step();
        end
        read_i = 3'b000;
        step();

        // Latched request stays stable while the requester changes
        write_i = 3'b001;
        set_port(0, 32'h40, 64'h1234_5678_9ABC_DEF0);
        step();
        set_port(0, 32'h80, 64'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("latch_addr",  64'(l2_addr_o),  64'h40);
            check_eq("latch_write", 64'(l2_write_o), 64'd1);
            step();
        end
        l2_resp_i = 1'b1;
        step();
        l2_resp_i = 1'b0;
        write_i   = 3'b000;
        step();
        step();

        // Read and write together on port 2: write wins
        read_i  = 3'b100;
        write_i = 3'b100;
        set_port(2, 32'h200, 64'hCAFE);
        step();
        read_i  = 3'b000;
        write_i = 3'b000;
        #1;
        check_eq("rw_write", 64'(l2_write_o), 64'd1);
        check_eq("rw_read",  64'(l2_read_o),  64'd0);
        l2_resp_i = 1'b1;
        #1;
        check_eq("rw_resp", 64'(resp_o), 64'h4);
        step();
        #1;
        check_eq("rw_no_second", 64'(resp_o), 64'd0);
        l2_resp_i = 1'b0;
        step();

        // Reset while a read is in flight, then a late response
        read_i = 3'b010;
        set_port(1, 32'h500, 64'd0);
        step();
        read_i = 3'b000;
        #1;
        check_eq("mr_strobe", 64'(l2_read_o), 64'd1);
        step();
        reset_n = 1'b0;
        step();
        reset_n   = 1'b1;
        l2_resp_i = 1'b1;
        #1;
        check_eq("mr_resp",  64'(resp_o),    64'd0);
        check_eq("mr_busy",  64'(busy_o),    64'd0);
        check_eq("mr_read",  64'(l2_read_o), 64'd0);
        step();
        l2_resp_i = 1'b0;
        read_i    = 3'b111;
        step();
        read_i = 3'b000;
        #1;
        check_eq("mr_ptr0", 64'(grant_o), 64'd0);
        l2_resp_i = 1'b1;
        step();
        l2_resp_i = 1'b0;
        step();

        // Spurious response while idle; pointer must stay at 1
        l2_resp_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("sp_resp", 64'(resp_o), 64'd0);
            check_eq("sp_busy", 64'(busy_o), 64'd0);
            step();
        end
        l2_resp_i = 1'b0;
        read_i    = 3'b011;
        step();
        read_i = 3'b000;
        #1;
        check_eq("sp_ptr", 64'(grant_o), 64'd1);
        l2_resp_i = 1'b1;
        step();
        l2_resp_i = 1'b0;
        step();

        // Random traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            reset_n    = ($urandom_range(63) != 0);
            read_i     = NP'($urandom);
            write_i    = NP'($urandom) & NP'($urandom);
            if ($urandom_range(3) == 0) begin
                read_i  = '0;
                write_i = '0;
            end
            for (int k = 0; k < NP; k++) set_port(k, $urandom, {$urandom, $urandom});
            l2_resp_i  = ($urandom_range(2) == 0);
            l2_rdata_i = {$urandom, $urandom};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
